// File: rtl/fifo_status.sv
// Synchronous show-ahead FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow error flags and a synchronous flush.
module fifo_status #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              rd,
  output logic [DATA_W-1:0] r_data,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  input  logic              err_clr
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   AF_C    = (ADDR_W + 1)'(AF_LEVEL);
  localparam logic [ADDR_W:0]   AE_C    = (ADDR_W + 1)'(AE_LEVEL);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   CNT_ZRO = (ADDR_W + 1)'(0);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ZRO = ADDR_W'(0);

  generate
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
      $error("fifo_status: AF_LEVEL must lie in 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL >= DEPTH) begin : g_bad_ae
      $error("fifo_status: AE_LEVEL must lie in 0..DEPTH-1");
    end
  endgenerate

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [ADDR_W:0]   r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_af;
  logic              r_ae;
  logic              r_ovf;
  logic              r_udf;

  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_ovf_evt;
  logic              w_udf_evt;
  logic [ADDR_W-1:0] w_wptr_nxt;
  logic [ADDR_W-1:0] w_rptr_nxt;
  logic [ADDR_W:0]   w_count_nxt;
  logic              w_ovf_nxt;
  logic              w_udf_nxt;

  // Request qualification, next pointers/count and next sticky error state.
  always_comb begin
    w_rd_acc    = 1'b0;
    w_wr_acc    = 1'b0;
    w_ovf_evt   = 1'b0;
    w_udf_evt   = 1'b0;
    w_wptr_nxt  = r_wptr;
    w_rptr_nxt  = r_rptr;
    w_count_nxt = r_count;
    if (flush) begin
      // Flush overrides any request in the same cycle, errors included.
      w_wptr_nxt  = PTR_ZRO;
      w_rptr_nxt  = PTR_ZRO;
      w_count_nxt = CNT_ZRO;
    end else begin
      w_rd_acc  = rd && !r_empty;
      w_wr_acc  = wr && (!r_full || w_rd_acc);
      w_ovf_evt = wr && r_full && !w_rd_acc;
      w_udf_evt = rd && r_empty;
      if (w_wr_acc) begin
        w_wptr_nxt = r_wptr + PTR_ONE;
      end else begin
        w_wptr_nxt = r_wptr;
      end
      if (w_rd_acc) begin
        w_rptr_nxt = r_rptr + PTR_ONE;
      end else begin
        w_rptr_nxt = r_rptr;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   w_count_nxt = r_count + CNT_ONE;
        2'b01:   w_count_nxt = r_count - CNT_ONE;
        default: w_count_nxt = r_count;
      endcase
    end
    w_ovf_nxt = w_ovf_evt || (r_ovf && !err_clr);
    w_udf_nxt = w_udf_evt || (r_udf && !err_clr);
  end

  // Pointers, occupancy, status flags and sticky errors.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= PTR_ZRO;
      r_rptr  <= PTR_ZRO;
      r_count <= CNT_ZRO;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_af    <= 1'b0;
      r_ae    <= 1'b1;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == DEPTH_C);
      r_empty <= (w_count_nxt == CNT_ZRO);
      r_af    <= (w_count_nxt >= AF_C);
      r_ae    <= (w_count_nxt <= AE_C);
      r_ovf   <= w_ovf_nxt;
      r_udf   <= w_udf_nxt;
    end
  end

  // Storage array; deliberately not reset so flush leaves old contents in place.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wptr] <= w_data;
    end else begin
      r_mem[r_wptr] <= r_mem[r_wptr];
    end
  end

  assign r_data       = r_mem[r_rptr];
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign count        = r_count;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule

// File: tb/tb_fifo_status.sv
// Directed self-checking bench for fifo_status with default parameters.
module tb_fifo_status;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       wr;
  logic [7:0] w_data;
  logic       rd;
  logic [7:0] r_data;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;
  logic       err_clr;

  int checks;
  int errors;

  fifo_status dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr(wr), .w_data(w_data), .rd(rd),
    .r_data(r_data), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .overflow(overflow),
    .underflow(underflow), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr = 1'b0; rd = 1'b0; flush = 1'b0; err_clr = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; flush = 1'b0; wr = 1'b0; rd = 1'b0; err_clr = 1'b0; w_data = 8'h00;
    step(); step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ae", 32'(almost_empty), 32'd1);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_udf", 32'(underflow), 32'd0);
    rst_n = 1'b1;
    step();

    // Test 1: set an error, load 5 words, then async reset mid-cycle.
    rd = 1'b1; step(); idle();
    chk("t1_udf_set", 32'(underflow), 32'd1);
    for (int i = 0; i < 5; i++) begin
      wr = 1'b1; w_data = 8'(8'h10 + i); step();
    end
    idle();
    chk("t1_count5", 32'(count), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_arst_count", 32'(count), 32'd0);
    chk("t1_arst_empty", 32'(empty), 32'd1);
    chk("t1_arst_ae", 32'(almost_empty), 32'd1);
    chk("t1_arst_udf", 32'(underflow), 32'd0);
    rst_n = 1'b1;
    step();

    // Test 2: fill, overflow, flags.
    for (int i = 0; i < 16; i++) begin
      wr = 1'b1; w_data = 8'(i); step();
      chk("t2_count", 32'(count), 32'(i + 1));
      chk("t2_af", 32'(almost_full), 32'((i + 1) >= 12));
      chk("t2_full", 32'(full), 32'((i + 1) == 16));
      chk("t2_ae", 32'(almost_empty), 32'((i + 1) <= 2));
    end
    w_data = 8'hAA; step(); idle();
    chk("t2_ovf", 32'(overflow), 32'd1);
    chk("t2_count16", 32'(count), 32'd16);

    // Test 3: drain with readback, then underflow.
    for (int i = 0; i < 16; i++) begin
      chk("t3_data", 32'(r_data), 32'(i));
      rd = 1'b1; step();
      chk("t3_count", 32'(count), 32'(15 - i));
      chk("t3_ae", 32'(almost_empty), 32'((15 - i) <= 2));
      chk("t3_empty", 32'(empty), 32'((15 - i) == 0));
    end
    chk("t3_no_udf", 32'(underflow), 32'd0);
    step(); idle();
    chk("t3_udf", 32'(underflow), 32'd1);
    chk("t3_count0", 32'(count), 32'd0);

    // Test 4: simultaneous read/write when full and when empty.
    err_clr = 1'b1; step(); idle();
    chk("t4_clr_ovf", 32'(overflow), 32'd0);
    chk("t4_clr_udf", 32'(underflow), 32'd0);
    for (int i = 0; i < 16; i++) begin
      wr = 1'b1; w_data = 8'(8'h20 + i); step();
    end
    wr = 1'b1; rd = 1'b1; w_data = 8'h55; step(); idle();
    chk("t4_full_count", 32'(count), 32'd16);
    chk("t4_full_ovf", 32'(overflow), 32'd0);
    for (int i = 1; i < 16; i++) begin
      chk("t4_data", 32'(r_data), 32'(8'h20 + i));
      rd = 1'b1; step();
    end
    chk("t4_last", 32'(r_data), 32'h55);
    step(); idle();
    chk("t4_empty", 32'(empty), 32'd1);
    wr = 1'b1; rd = 1'b1; w_data = 8'h33; step(); idle();
    chk("t4_e_count", 32'(count), 32'd1);
    chk("t4_e_udf", 32'(underflow), 32'd1);
    chk("t4_e_data", 32'(r_data), 32'h33);
    rd = 1'b1; step(); idle();

    // Test 5: repeated bursts of 3 past pointer wrap.
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < 3; j++) begin
        wr = 1'b1; w_data = 8'(8'h40 + k * 3 + j); step();
      end
      idle();
      chk("t5_count3", 32'(count), 32'd3);
      for (int j = 0; j < 3; j++) begin
        chk("t5_data", 32'(r_data), 32'(8'h40 + k * 3 + j));
        rd = 1'b1; step();
      end
      idle();
      chk("t5_count0", 32'(count), 32'd0);
    end

    // Test 6: flush discards a concurrent write; err_clr behaviour.
    for (int i = 0; i < 7; i++) begin
      wr = 1'b1; w_data = 8'(8'h60 + i); step();
    end
    idle();
    chk("t6_count7", 32'(count), 32'd7);
    flush = 1'b1; wr = 1'b1; w_data = 8'h77; step(); idle();
    chk("t6_fl_count", 32'(count), 32'd0);
    chk("t6_fl_empty", 32'(empty), 32'd1);
    chk("t6_fl_ae", 32'(almost_empty), 32'd1);
    chk("t6_fl_udf_kept", 32'(underflow), 32'd1);
    wr = 1'b1; w_data = 8'h99; step(); idle();
    chk("t6_post_data", 32'(r_data), 32'h99);
    chk("t6_post_count", 32'(count), 32'd1);
    for (int i = 0; i < 15; i++) begin
      wr = 1'b1; w_data = 8'(8'h80 + i); step();
    end
    chk("t6_fullfill", 32'(full), 32'd1);
    w_data = 8'hAA; step(); idle();
    chk("t6_ovf", 32'(overflow), 32'd1);
    err_clr = 1'b1; step(); idle();
    chk("t6_clr", 32'(overflow), 32'd0);
    wr = 1'b1; err_clr = 1'b1; w_data = 8'hBB; step(); idle();
    chk("t6_clr_vs_evt", 32'(overflow), 32'd1);
    chk("t6_count16", 32'(count), 32'd16);
    chk("t6_head", 32'(r_data), 32'h99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

endmodule
